// File: rtl/car_sense_pkg.sv
// Shared types and constants for the car_sense vehicle-detection front end.
package car_sense_pkg;

  typedef enum logic [1:0] {
    IDLE,
    QUAL,
    REQ,
    SERVED
  } chan_state_e;

  localparam int unsigned NS_GREEN_BIT = 3;
  localparam int unsigned EW_GREEN_BIT = 0;

endpackage

// File: rtl/car_sense_chan.sv
// One road-loop channel: optional 2-flop synchroniser, debounce counter and request FSM.
// CAR_SENSE_SYNC_EN selects the synchroniser; without it the raw input is used directly.
module car_sense_chan
  import car_sense_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  input  logic green,
  output logic req
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s;
  chan_state_e      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             req_n;

`ifdef CAR_SENSE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) sync_q <= '0;
    else     sync_q <= {sync_q[0], raw};
  end

  assign s = sync_q[1];
`else
  assign s = raw;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      req   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      req   <= req_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_n = REQ;
          end else begin
            state_n = QUAL;
            cnt_n   = CNT_W'(1);
          end
        end
      end
      QUAL: begin
        if (!s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = REQ;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      // Request survives the car leaving; only green retires it.
      REQ: begin
        if (green) state_n = SERVED;
      end
      SERVED: begin
        if (!s) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Decoding the next state keeps req aligned with the state register.
  always_comb begin
    req_n = (state_n == REQ);
  end

endmodule

// File: rtl/car_sense.sv
// Vehicle-detection front end: two independent loop channels feeding nscar/ewcar.
// Define CAR_SENSE_SYNC_EN to add a 2-flop synchroniser on each raw input.
module car_sense
  import car_sense_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ns_raw,
  input  logic       ew_raw,
  input  logic [5:0] lights,
  output logic       nscar,
  output logic       ewcar
);

  logic unused_lights;
  assign unused_lights = ^{lights[5:4], lights[2:1]};

  car_sense_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ns (
    .clk  (clk),
    .clr  (clr),
    .raw  (ns_raw),
    .green(lights[NS_GREEN_BIT]),
    .req  (nscar)
  );

  car_sense_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ew (
    .clk  (clk),
    .clr  (clr),
    .raw  (ew_raw),
    .green(lights[EW_GREEN_BIT]),
    .req  (ewcar)
  );

endmodule

// File: tb/tb_car_sense.sv
// Scoreboard bench for car_sense: directed scenarios plus random loop/light traffic.
module tb_car_sense;

  localparam int unsigned D = 4;
`ifdef CAR_SENSE_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       ns_raw = 1'b0;
  logic       ew_raw = 1'b0;
  logic [5:0] lights = '0;
  logic       nscar, ewcar;

  car_sense #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .clk   (clk),
    .clr   (clr),
    .ns_raw(ns_raw),
    .ew_raw(ew_raw),
    .lights(lights),
    .nscar (nscar),
    .ewcar (ewcar)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic ns;
    logic ew;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference state per road (0 = NS, 1 = EW)
  int unsigned run[2];
  bit          pend[2];
  bit          blk[2];
  bit          sh0[2];
  bit          sh1[2];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      run[c] = 0; pend[c] = 0; blk[c] = 0; sh0[c] = 0; sh1[c] = 0;
    end
  endtask

  // Drive one cycle of inputs, then advance the model on the consuming edge.
  task automatic cyc(input logic ns, input logic ew, input logic [5:0] l);
    bit s;
    bit raw[2];
    bit g[2];
    #3;
    ns_raw = ns; ew_raw = ew; lights = l;
    @(posedge clk);
    raw[0] = ns; raw[1] = ew; g[0] = l[3]; g[1] = l[0];
    for (int c = 0; c < 2; c++) begin
      if (SYNC) begin
        s = sh1[c]; sh1[c] = sh0[c]; sh0[c] = raw[c];
      end else begin
        s = raw[c];
      end
      if (pend[c]) begin
        if (g[c]) begin pend[c] = 0; blk[c] = 1; end
      end else if (blk[c]) begin
        if (!s) blk[c] = 0;
      end else if (s) begin
        run[c]++;
        if (run[c] == D) begin pend[c] = 1; run[c] = 0; end
      end else begin
        run[c] = 0;
      end
    end
    q.push_back('{ns: pend[0], ew: pend[1]});
  endtask

  task automatic hold(input logic ns, input logic ew, input logic [5:0] l, input int n);
    for (int i = 0; i < n; i++) cyc(ns, ew, l);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("nscar", nscar, e.ns);
        chk("ewcar", ewcar, e.ew);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    bit          ns_r, ew_r;
    logic [5:0]  l;
    int          waited;
    model_reset();
    #1;
    chk("reset_nscar", nscar, 1'b0);
    chk("reset_ewcar", ewcar, 1'b0);
    repeat (2) @(posedge clk);
    #3 clr = 1'b0;

    // Qualify NS, then an asynchronous clear while the request is up
    hold(1, 0, '0, 8);
    #3;
    clr = 1'b1; ns_raw = 1'b0;
    #1;
    chk("async_clr_nscar", nscar, 1'b0);
    chk("async_clr_ewcar", ewcar, 1'b0);
    model_reset();
    @(posedge clk);
    #3 clr = 1'b0;
    hold(0, 0, '0, 6);

    // EW glitch restarts qualification
    hold(0, 1, '0, 3);
    hold(0, 0, '0, 1);
    hold(0, 1, '0, 8);
    hold(0, 1, 6'b000001, 1);
    hold(0, 0, '0, 3);

    // NS service, no re-request while held, requalify after drop
    hold(1, 0, '0, 8);
    hold(1, 0, 6'b001100, 1);
    hold(1, 0, '0, 6);
    hold(0, 0, '0, 2);
    hold(1, 0, '0, 8);
    hold(0, 0, 6'b001100, 1);
    hold(0, 0, '0, 3);

    // Latched departure on EW
    hold(0, 1, '0, 7);
    hold(0, 0, '0, 20);
    hold(0, 0, 6'b000001, 1);
    hold(0, 0, '0, 3);

    // Simultaneous qualification, EW served alone first
    hold(1, 1, '0, 8);
    hold(1, 1, 6'b100001, 1);
    hold(1, 1, '0, 3);
    hold(1, 1, 6'b001100, 1);
    hold(0, 0, '0, 4);

    // Random traffic with sticky loop inputs and sparse greens
    ns_r = 0; ew_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) ns_r = ~ns_r;
      if ($urandom_range(5) == 0) ew_r = ~ew_r;
      l = 6'($urandom) & 6'b110110;
      if ($urandom_range(9) == 0) l[3] = 1'b1;
      if ($urandom_range(9) == 0) l[0] = 1'b1;
      cyc(ns_r, ew_r, l);
    end
    hold(0, 0, '0, 2);

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #4;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected samples left, required 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
